// File: rtl/adc_cfg_sequencer_if.sv
// Request/accept/done handshake between the configuration sequencer and the
// AD9648 serial-port engine.
interface adc_cfg_sequencer_if;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 8;

  logic              spi_req;
  logic              spi_ack;
  logic              spi_rw;
  logic              spi_cs_sel;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_wdata;
  logic              spi_done;
  logic [DATA_W-1:0] spi_rdata;

  modport master (
    output spi_req, spi_rw, spi_cs_sel, spi_addr, spi_wdata,
    input  spi_ack, spi_done, spi_rdata
  );

  modport slave (
    input  spi_req, spi_rw, spi_cs_sel, spi_addr, spi_wdata,
    output spi_ack, spi_done, spi_rdata
  );
endinterface

// File: rtl/adc_cfg_sequencer.sv
// Walks the register table, writing and verifying each entry on ADC1 then
// ADC2, and finishes each chip with a transfer-register write.
module adc_cfg_sequencer #(
  parameter int unsigned TBL_DEPTH_W = 5,
  parameter int unsigned MAX_RETRY   = 3,
  parameter logic [15:0] TIMEOUT     = 16'd4096
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic [TBL_DEPTH_W-1:0] tbl_idx,
  input  logic [12:0]            tbl_addr,
  input  logic [7:0]             tbl_data,
  input  logic                   tbl_last,
  adc_cfg_sequencer_if.master    spi,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   err_chip,
  output logic [TBL_DEPTH_W-1:0] err_idx,
  output logic                   err_timeout
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [12:0] XF_ADDR = 13'h0FF;
  localparam logic [7:0]  XF_DATA = 8'h01;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT,
    S_CHECK, S_NEXT, S_XF_REQ, S_XF_WAIT, S_DONE, S_ERROR
  } state_t;

  state_t             state;
  state_t             wait_state_c;
  logic [RETRY_W-1:0] retry;
  logic               last_q;
  logic [7:0]         rdata_q;
  logic [15:0]        to_cnt;
  logic               is_req_c;
  logic               is_wait_c;
  logic               accept_c;
  logic               finish_c;
  logic               expired_c;

  // Handshake decode shared by the write, read and transfer phases
  always_comb begin
    wait_state_c = state;
    is_req_c     = 1'b0;
    is_wait_c    = 1'b0;
    case (state)
      S_WR_REQ:  begin is_req_c = 1'b1; wait_state_c = S_WR_WAIT; end
      S_RD_REQ:  begin is_req_c = 1'b1; wait_state_c = S_RD_WAIT; end
      S_XF_REQ:  begin is_req_c = 1'b1; wait_state_c = S_XF_WAIT; end
      S_WR_WAIT, S_RD_WAIT, S_XF_WAIT: is_wait_c = 1'b1;
      default: ;
    endcase
    accept_c  = is_req_c & spi.spi_ack;
    finish_c  = spi.spi_done & (is_wait_c | accept_c);
    expired_c = is_wait_c & (to_cnt == TIMEOUT);
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      tbl_idx        <= '0;
      retry          <= '0;
      last_q         <= 1'b0;
      rdata_q        <= '0;
      to_cnt         <= '0;
      spi.spi_req    <= 1'b0;
      spi.spi_rw     <= 1'b0;
      spi.spi_cs_sel <= 1'b0;
      spi.spi_addr   <= '0;
      spi.spi_wdata  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_chip       <= 1'b0;
      err_idx        <= '0;
      err_timeout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state          <= S_LOAD;
            tbl_idx        <= '0;
            retry          <= '0;
            spi.spi_cs_sel <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            err_chip       <= 1'b0;
            err_idx        <= '0;
            err_timeout    <= 1'b0;
          end
        end

        // The table is only sampled here; spi_wdata doubles as the compare value
        S_LOAD: begin
          spi.spi_addr  <= tbl_addr;
          spi.spi_wdata <= tbl_data;
          last_q        <= tbl_last;
          spi.spi_rw    <= 1'b0;
          spi.spi_req   <= 1'b1;
          state         <= S_WR_REQ;
        end

        S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_XF_REQ, S_XF_WAIT: begin
          if (accept_c) begin
            spi.spi_req <= 1'b0;
            to_cnt      <= '0;
            state       <= wait_state_c;
          end else if (is_wait_c) begin
            to_cnt <= to_cnt + 16'd1;
          end

          // A done in the accept cycle skips the wait state entirely
          if (finish_c) begin
            if (state inside {S_WR_REQ, S_WR_WAIT}) begin
              spi.spi_rw  <= 1'b1;
              spi.spi_req <= 1'b1;
              state       <= S_RD_REQ;
            end else if (state inside {S_RD_REQ, S_RD_WAIT}) begin
              rdata_q <= spi.spi_rdata;
              state   <= S_CHECK;
            end else if (!spi.spi_cs_sel) begin
              spi.spi_cs_sel <= 1'b1;
              tbl_idx        <= '0;
              state          <= S_LOAD;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end else if (expired_c) begin
            spi.spi_req <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b1;
            err_timeout <= 1'b1;
            err_chip    <= spi.spi_cs_sel;
            err_idx     <= (state == S_XF_WAIT) ? '1 : tbl_idx;
            state       <= S_ERROR;
          end
        end

        S_CHECK: begin
          if (rdata_q == spi.spi_wdata) begin
            state <= S_NEXT;
          end else if (32'(retry) < MAX_RETRY) begin
            retry       <= retry + RETRY_W'(1);
            spi.spi_rw  <= 1'b0;
            spi.spi_req <= 1'b1;
            state       <= S_WR_REQ;
          end else begin
            busy        <= 1'b0;
            error       <= 1'b1;
            err_timeout <= 1'b0;
            err_chip    <= spi.spi_cs_sel;
            err_idx     <= tbl_idx;
            state       <= S_ERROR;
          end
        end

        // A full table without a last marker still ends at the top index
        S_NEXT: begin
          retry <= '0;
          if (last_q || (&tbl_idx)) begin
            spi.spi_addr  <= XF_ADDR;
            spi.spi_wdata <= XF_DATA;
            spi.spi_rw    <= 1'b0;
            spi.spi_req   <= 1'b1;
            state         <= S_XF_REQ;
          end else begin
            tbl_idx <= tbl_idx + TBL_DEPTH_W'(1);
            state   <= S_LOAD;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Bench for adc_cfg_sequencer: a randomized-latency serial engine model logs
// every transaction and a table-driven reference predicts the full sequence.
module tb_adc_cfg_sequencer;
  localparam int unsigned DW = 5;
  localparam int unsigned MR = 3;
  localparam logic [15:0] TO = 16'd16;
  localparam int          FOREVER = 1000;

  logic          sys_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start   = 1'b0;
  logic [DW-1:0] tbl_idx;
  logic [12:0]   tbl_addr;
  logic [7:0]    tbl_data;
  logic          tbl_last;
  logic          busy, done, error, err_chip, err_timeout;
  logic [DW-1:0] err_idx;

  logic [12:0] tbl_a [32];
  logic [7:0]  tbl_d [32];
  int          tbl_n;

  always #5 sys_clk = ~sys_clk;

  assign tbl_addr = tbl_a[tbl_idx];
  assign tbl_data = tbl_d[tbl_idx];
  assign tbl_last = (int'(tbl_idx) == tbl_n - 1);

  adc_cfg_sequencer_if spi ();

  adc_cfg_sequencer #(.TBL_DEPTH_W(DW), .MAX_RETRY(MR), .TIMEOUT(TO)) u_dut (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .start       (start),
    .tbl_idx     (tbl_idx),
    .tbl_addr    (tbl_addr),
    .tbl_data    (tbl_data),
    .tbl_last    (tbl_last),
    .spi         (spi.master),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_chip    (err_chip),
    .err_idx     (err_idx),
    .err_timeout (err_timeout)
  );

  int checks = 0;
  int errors = 0;

  // engine model controls
  int          ack_max  = 2;
  int          done_min = 0;
  int          done_max = 3;
  logic        hang_xf0 = 1'b0;
  logic        f_chip   = 1'b0;
  logic [12:0] f_addr   = 13'h1FFF;
  int          f_bad    = 0;
  logic [7:0]  f_val    = 8'h00;
  logic [22:0] log_q [$];
  logic [7:0]  last_w [2];

  // reference expectations
  logic [22:0] exp_q [$];
  logic        exp_err;
  logic        exp_to;
  logic        exp_chip;
  logic [DW-1:0] exp_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Serial engine: random ack latency, random done latency (0 = same cycle as ack)
  initial begin : engine
    int          ad, dd;
    logic [22:0] t;
    logic        hang;
    logic [7:0]  rd;
    spi.spi_ack   = 1'b0;
    spi.spi_done  = 1'b0;
    spi.spi_rdata = 8'h00;
    last_w[0]     = 8'h00;
    last_w[1]     = 8'h00;
    forever begin
      @(negedge sys_clk);
      if (spi.spi_req === 1'b1 && reset_n) begin
        ad = int'($urandom_range(ack_max, 0));
        repeat (ad) @(negedge sys_clk);
        t = {spi.spi_cs_sel, spi.spi_rw, spi.spi_addr, spi.spi_rw ? 8'h00 : spi.spi_wdata};
        log_q.push_back(t);
        hang = hang_xf0 && !spi.spi_cs_sel && !spi.spi_rw && (spi.spi_addr == 13'h0FF);
        if (!spi.spi_rw) last_w[spi.spi_cs_sel] = spi.spi_wdata;
        rd = last_w[spi.spi_cs_sel];
        if (spi.spi_rw && spi.spi_cs_sel == f_chip && spi.spi_addr == f_addr && f_bad > 0) begin
          rd = f_val;
          f_bad--;
        end
        dd = int'($urandom_range(done_max, done_min));
        spi.spi_ack = 1'b1;
        if (dd == 0 && !hang) begin
          spi.spi_done  = 1'b1;
          spi.spi_rdata = rd;
        end
        @(negedge sys_clk);
        spi.spi_ack  = 1'b0;
        spi.spi_done = 1'b0;
        if (dd > 0 && !hang) begin
          repeat (dd - 1) @(negedge sys_clk);
          spi.spi_done  = 1'b1;
          spi.spi_rdata = rd;
          @(negedge sys_clk);
          spi.spi_done = 1'b0;
        end
      end
    end
  end

  // Reference: per chip, each entry is written and read (extra pairs for bad
  // reads, capped at MR+1 attempts), then the transfer write 0x0FF=0x01.
  task automatic build_exp(input int n, input int fchip, input int fidx, input int fbad,
                           input bit hang);
    int neff;
    int tries;
    neff = (n > 32) ? 32 : n;
    exp_q.delete();
    exp_err = 1'b0; exp_to = 1'b0; exp_chip = 1'b0; exp_idx = '0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < neff; i++) begin
        tries = (c == fchip && i == fidx) ? fbad + 1 : 1;
        if (tries > int'(MR) + 1) tries = int'(MR) + 1;
        for (int a = 0; a < tries; a++) begin
          exp_q.push_back({1'(c), 1'b0, tbl_a[i], tbl_d[i]});
          exp_q.push_back({1'(c), 1'b1, tbl_a[i], 8'h00});
        end
        if (c == fchip && i == fidx && fbad > int'(MR)) begin
          exp_err = 1'b1; exp_chip = 1'(c); exp_idx = DW'(i);
          return;
        end
      end
      exp_q.push_back({1'(c), 1'b0, 13'h0FF, 8'h01});
      if (hang && c == 0) begin
        exp_err = 1'b1; exp_to = 1'b1; exp_chip = 1'b0; exp_idx = '1;
        return;
      end
    end
  endtask

  task automatic set_nominal();
    tbl_n = 3;
    tbl_a[0] = 13'h014; tbl_d[0] = 8'h01;
    tbl_a[1] = 13'h016; tbl_d[1] = 8'h80;
    tbl_a[2] = 13'h018; tbl_d[2] = 8'h04;
  endtask

  task automatic pulse_start();
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic begin_run(input string tag);
    log_q.delete();
    pulse_start();
    chk({tag, "_busy_at_start"}, 32'(busy), 32'd1);
    chk({tag, "_clear_at_start"}, {done, error, err_timeout, err_chip, 3'b0, err_idx}, 32'd0);
  endtask

  task automatic finish_run(input string tag);
    int k;
    k = 0;
    while (!(done || error) && k < 20000) begin
      @(negedge sys_clk);
      k++;
    end
    chk({tag, "_terminated"}, 32'(done || error), 32'd1);
    repeat (4) @(negedge sys_clk);
    chk({tag, "_txn_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_txn%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    chk({tag, "_done"}, 32'(done), 32'(!exp_err));
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
    chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_req_idle"}, 32'(spi.spi_req), 32'd0);
    if (exp_err) begin
      chk({tag, "_err_chip"}, 32'(err_chip), 32'(exp_chip));
      chk({tag, "_err_idx"}, 32'(err_idx), 32'(exp_idx));
      chk({tag, "_err_timeout"}, 32'(err_timeout), 32'(exp_to));
    end
  endtask

  task automatic set_fault(input logic chip, input logic [12:0] addr, input int n,
                           input logic [7:0] v);
    f_chip = chip; f_addr = addr; f_bad = n; f_val = v;
  endtask

  initial begin : stimulus
    int n, mode, fc, fi, fb, lat;
    for (int i = 0; i < 32; i++) begin tbl_a[i] = 13'h0; tbl_d[i] = 8'h0; end
    set_nominal();

    // reset values
    repeat (3) @(negedge sys_clk);
    chk("rst_outputs_low", {busy, done, error, err_chip, err_timeout, spi.spi_req,
                            spi.spi_rw, spi.spi_cs_sel}, 32'd0);
    chk("rst_idx", {3'b0, tbl_idx, 3'b0, err_idx}, 32'd0);
    chk("rst_addr_wdata", {spi.spi_addr, spi.spi_wdata}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("post_rst_idle", {busy, done, error, spi.spi_req}, 32'd0);

    // nominal 3-entry table, 14 transactions
    build_exp(3, -1, 0, 0, 1'b0);
    chk("nominal_model_len", 32'(exp_q.size()), 32'd14);
    begin_run("nominal");
    finish_run("nominal");

    // one bad readback of entry 1 on chip 0
    set_fault(1'b0, 13'h016, 1, 8'h00);
    build_exp(3, 0, 1, 1, 1'b0);
    begin_run("retry1");
    finish_run("retry1");

    // entry 2 on chip 1 never reads back correctly
    set_fault(1'b1, 13'h018, FOREVER, 8'hFF);
    build_exp(3, 1, 2, FOREVER, 1'b0);
    begin_run("persist");
    finish_run("persist");
    set_fault(1'b0, 13'h1FFF, 0, 8'h00);

    // chip-0 transfer write never completes
    hang_xf0 = 1'b1;
    build_exp(3, -1, 0, 0, 1'b1);
    begin_run("timeout");
    n = 0;
    while (n < 5000 && !(spi.spi_ack && spi.spi_addr == 13'h0FF && !spi.spi_cs_sel)) begin
      @(posedge sys_clk);
      n++;
    end
    chk("timeout_xf_ack_seen", 32'(n < 5000), 32'd1);
    lat = 0;
    #1;
    while (!error && lat < 100) begin
      @(posedge sys_clk);
      lat++;
      #1;
      if (lat < int'(TO)) chk("timeout_not_early", 32'(error), 32'd0);
    end
    chk("timeout_latency", 32'(lat >= int'(TO) && lat <= int'(TO) + 1), 32'd1);
    finish_run("timeout");
    hang_xf0 = 1'b0;

    // asynchronous reset while waiting for the read of entry 1
    done_min = 1;
    build_exp(3, -1, 0, 0, 1'b0);
    begin_run("rstmid");
    n = 0;
    while (n < 5000 && !(spi.spi_ack && spi.spi_rw && tbl_idx == DW'(1))) begin
      @(posedge sys_clk);
      n++;
    end
    chk("rstmid_rd_ack_seen", 32'(n < 5000), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_async_low", {busy, done, error, spi.spi_req, spi.spi_rw, spi.spi_cs_sel,
                             err_chip, err_timeout}, 32'd0);
    chk("rstmid_async_idx_addr", {tbl_idx, spi.spi_addr, spi.spi_wdata}, 32'd0);
    @(negedge sys_clk);
    reset_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    done_min = 0;
    begin_run("restart");
    chk("restart_idx_chip", {tbl_idx, spi.spi_cs_sel}, 32'd0);
    finish_run("restart");

    // 32 entries with no last marker: index all-ones ends the table
    tbl_n = 99;
    for (int i = 0; i < 32; i++) begin
      tbl_a[i] = 13'h100 + 13'(i * 16) + 13'($urandom_range(15, 0));
      tbl_d[i] = 8'($urandom);
    end
    build_exp(99, -1, 0, 0, 1'b0);
    begin_run("full32");
    finish_run("full32");

    // randomized tables and faults, with start pulsed while busy
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(6, 1));
      tbl_n = n;
      for (int i = 0; i < n; i++) begin
        tbl_a[i] = 13'h100 + 13'(i * 16) + 13'($urandom_range(15, 0));
        tbl_d[i] = 8'($urandom);
      end
      mode = int'($urandom_range(2, 0));
      fc = int'($urandom_range(1, 0));
      fi = int'($urandom_range(n - 1, 0));
      fb = (mode == 0) ? 0 : (mode == 1) ? int'($urandom_range(MR, 1)) : FOREVER;
      if (mode == 0) set_fault(1'b0, 13'h1FFF, 0, 8'h00);
      else           set_fault(1'(fc), tbl_a[fi], fb, ~tbl_d[fi]);
      build_exp(n, (mode == 0) ? -1 : fc, fi, fb, 1'b0);
      begin_run($sformatf("rand%0d", r));
      repeat (3) @(negedge sys_clk);
      pulse_start();
      repeat (4) @(negedge sys_clk);
      pulse_start();
      finish_run($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_cfg_sequencer.md
# adc_cfg_sequencer

Configuration sequencer for the dual AD9648 serial port. On a start pulse it walks an external register table and writes each entry to ADC1, then ADC2, through the serial-port engine. It reads every register back and compares it, retrying on mismatch, then issues the transfer-register write (0x0FF = 0x01) per chip. It sits between system control and the serial-port engine, and reports done/error with the failing table index.

## Interface
- `TBL_DEPTH_W`, 5: table index width (up to 32 entries)
- `MAX_RETRY`, 3: extra write+readback attempts per entry before error
- `TIMEOUT`, 16'd4096: `sys_clk` cycles allowed between request accept and `spi_done`
- `sys_clk`  in  1  system clock (26 MHz), all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; ignored unless state is IDLE, DONE or ERROR
- `tbl_idx`  out  TBL_DEPTH_W  current table index
- `tbl_addr`  in  13  register address of entry `tbl_idx`, combinational, valid same cycle
- `tbl_data`  in  8  register data of entry `tbl_idx`
- `tbl_last`  in  1  entry `tbl_idx` is the final entry
- `spi_req`  out  1  transaction request, held until `spi_ack`
- `spi_ack`  in  1  one-cycle accept from engine
- `spi_rw`  out  1  0 = write, 1 = read (R/W bit of instruction word)
- `spi_cs_sel`  out  1  0 = ADC1 (CSB1), 1 = ADC2 (CSB2)
- `spi_addr`  out  13  instruction address
- `spi_wdata`  out  8  write data
- `spi_done`  in  1  one-cycle end of transaction; `spi_rdata` valid this cycle
- `spi_rdata`  in  8  readback byte
- `busy`  out  1  high in any state except IDLE/DONE/ERROR
- `done`  out  1  level, high in DONE
- `error`  out  1  level, high in ERROR
- `err_chip`  out  1  chip of failing entry
- `err_idx`  out  TBL_DEPTH_W  index of failing entry (`{TBL_DEPTH_W{1'b1}}` if the failure was the transfer write)
- `err_timeout`  out  1  1 = error caused by timeout, 0 = readback mismatch

## Operation
- **Reset values.** All outputs 0 (`tbl_idx` 0, `spi_*` outputs 0, `err_idx` 0); state IDLE.
- **States:** IDLE, LOAD, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, NEXT, XF_REQ, XF_WAIT, DONE, ERROR.
- **Start.** `start` in IDLE/DONE/ERROR -> LOAD, with `tbl_idx`=0, chip=0, retry=0, and `done`, `error` and all `err_*` cleared.
- **LOAD.** Latch `tbl_addr`/`tbl_data`/`tbl_last` into registers -> WR_REQ. The table is sampled only here.
- **WR_REQ.** `spi_req`=1, `spi_rw`=0, addr/wdata from latched entry; on `spi_ack` -> WR_WAIT.
- **WR_WAIT.** On `spi_done` -> RD_REQ.
- **RD_REQ / RD_WAIT.** Same handshake with `spi_rw`=1. On `spi_done`, capture `spi_rdata` -> CHECK.
- **CHECK.**
  - Equal -> NEXT.
  - Mismatch with retry < MAX_RETRY -> retry+1, WR_REQ.
  - Mismatch otherwise -> ERROR with `err_timeout`=0.
- **NEXT.** Clear retry.
  - If latched last: -> XF_REQ (transfer write 0x0FF = 0x01 to current chip).
  - Else: `tbl_idx`+1 -> LOAD.
  - If `tbl_idx` reaches all-ones without last, treat as last.
- **XF_REQ / XF_WAIT.** Write handshake, no readback; the register self-clears.
  - On `spi_done`, chip 0 -> chip=1, `tbl_idx`=0, LOAD.
  - On `spi_done`, chip 1 -> DONE.
- **Timeout.** The timeout counter runs in every *_WAIT state, cleared on entry. Reaching TIMEOUT -> ERROR with `err_timeout`=1, `err_chip`/`err_idx` set (transfer-write index all-ones).
- **Stray handshakes.** `spi_ack` outside *_REQ and `spi_done` outside *_WAIT are ignored.
- **Reset mid-operation.** Asynchronous return to IDLE; `spi_req` drops immediately. The engine is responsible for releasing CS on its own reset.

## Timing
- `spi_req` asserts the cycle after entering a *_REQ state and deasserts the cycle after `spi_ack` is sampled. Addr/rw/wdata/cs_sel are stable while `spi_req`=1 and until `spi_done`.
- `spi_ack` and `spi_done` in the same cycle: the request is accepted, the state goes directly to the successor of the *_WAIT state (done honoured).
- Overhead per entry outside the engine: LOAD 1 + REQ≥1 + CHECK 1 + NEXT 1 cycles.
- `done`/`error` assert the cycle after the final `spi_done`/CHECK/timeout and hold until the next `start`.
- Timeout fires on the cycle the counter equals TIMEOUT (TIMEOUT cycles after entering WAIT).

## Test plan
- **Nominal.** 3-entry table {0x014=0x01, 0x016=0x80, 0x018=0x04}, engine echoes written data -> exact sequence W/R ×3, W 0x0FF=0x01 on chip 0, repeated on chip 1; `done`=1, 14 transactions total.
- **Single retry.** Entry 1 on chip 0 returns 0x00 once, then 0x80 -> one extra W/R pair, then `done`=1, `error`=0.
- **Persistent mismatch.** Entry 2 on chip 1 always returns 0xFF, MAX_RETRY=3 -> 4 write/read pairs, then `error`=1, `err_chip`=1, `err_idx`=2, `err_timeout`=0, `spi_req`=0.
- **Timeout.** Engine never pulses `spi_done` on the chip-0 transfer write, TIMEOUT=16 -> `error`=1, `err_timeout`=1, `err_idx`=31, `err_chip`=0, 16 cycles after ack.
- **Async reset mid-read.** Deassert `reset_n` during RD_WAIT of entry 1 -> all outputs 0 within the same cycle. After release, `start` restarts from `tbl_idx`=0, chip 0.
- **Same-cycle ack/done and ignored start.** `spi_ack`=`spi_done` in the same cycle, plus `start` pulsed while busy -> state advances correctly, no duplicate request, sequence unaffected.
